// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one execute-stage ALU (with CMOV min-select front end) between two requesters.
// Optional per-requester saturating grant counters are enabled by defining ALU_ARB_GRANT_CNT_EN.
module alu_share_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 4
`ifdef ALU_ARB_GRANT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           r0_valid,
    output logic           r0_ready,
    input  logic [OPW-1:0] r0_op,
    input  logic [DW-1:0]  r0_a,
    input  logic [DW-1:0]  r0_b,
    input  logic           r0_cmov,
    input  logic           r1_valid,
    output logic           r1_ready,
    input  logic [OPW-1:0] r1_op,
    input  logic [DW-1:0]  r1_a,
    input  logic [DW-1:0]  r1_b,
    input  logic           r1_cmov,
    output logic           alu_is_cmov,
    output logic [OPW-1:0] alu_op,
    output logic [DW-1:0]  alu_a,
    output logic [DW-1:0]  alu_b,
    input  logic [DW-1:0]  alu_result,
`ifdef ALU_ARB_GRANT_CNT_EN
    output logic [CNT_W-1:0] gnt_cnt0,
    output logic [CNT_W-1:0] gnt_cnt1,
`endif
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic           rsp_id,
    output logic [DW-1:0]  rsp_data
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0] state;
    logic       rr_ptr;
    logic       gnt_id;
    logic       any_valid;
    logic       grant;

    // Pick the winner: a lone requester wins outright, a tie goes to rr_ptr.
    always_comb begin
        any_valid = r0_valid | r1_valid;
        grant     = (r0_valid & r1_valid) ? rr_ptr : r1_valid;
    end

    // Arbitration FSM; the ready pulse also marks the first EXEC cycle, so the
    // result is captured one cycle later, giving rsp_valid two cycles after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            gnt_id      <= 1'b0;
            r0_ready    <= 1'b0;
            r1_ready    <= 1'b0;
            alu_is_cmov <= 1'b0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= 1'b0;
            rsp_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        state       <= EXEC;
                        gnt_id      <= grant;
                        rr_ptr      <= ~grant;
                        r0_ready    <= ~grant;
                        r1_ready    <= grant;
                        alu_op      <= grant ? r1_op   : r0_op;
                        alu_a       <= grant ? r1_a    : r0_a;
                        alu_b       <= grant ? r1_b    : r0_b;
                        alu_is_cmov <= grant ? r1_cmov : r0_cmov;
                    end
                end
                EXEC: begin
                    r0_ready <= 1'b0;
                    r1_ready <= 1'b0;
                    if (!(r0_ready | r1_ready)) begin
                        rsp_data  <= alu_result;
                        rsp_id    <= gnt_id;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_GRANT_CNT_EN
    // Count accepted ops per requester, sticking at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_cnt0 <= '0;
            gnt_cnt1 <= '0;
        end else begin
            if (r0_ready && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
            if (r1_ready && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed plus random checks of alu_share_arbiter against a behavioural model.
module tb_alu_share_arbiter;
    localparam int DW  = 32;
    localparam int OPW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           r0_valid, r0_ready, r0_cmov;
    logic           r1_valid, r1_ready, r1_cmov;
    logic [OPW-1:0] r0_op, r1_op, alu_op;
    logic [DW-1:0]  r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_result, rsp_data;
    logic           alu_is_cmov, rsp_valid, rsp_ready, rsp_id;
`ifdef ALU_ARB_GRANT_CNT_EN
    logic [1:0]     gnt_cnt0, gnt_cnt1;
`endif

    logic [OPW-1:0] f_op [2];
    logic [DW-1:0]  f_a [2];
    logic [DW-1:0]  f_b [2];
    logic           f_cm [2];
    logic           v [2];
    int             last_gnt;
    int             errors = 0;
    int             checks = 0;
    int             lat;

    assign r0_valid = v[0];
    assign r0_op    = f_op[0];
    assign r0_a     = f_a[0];
    assign r0_b     = f_b[0];
    assign r0_cmov  = f_cm[0];
    assign r1_valid = v[1];
    assign r1_op    = f_op[1];
    assign r1_a     = f_a[1];
    assign r1_b     = f_b[1];
    assign r1_cmov  = f_cm[1];

    always #5 clk = ~clk;

    alu_share_arbiter #(
        .DW(DW),
        .OPW(OPW)
`ifdef ALU_ARB_GRANT_CNT_EN
        ,
        .CNT_W(2)
`endif
    ) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_op(r0_op), .r0_a(r0_a), .r0_b(r0_b), .r0_cmov(r0_cmov),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_op(r1_op), .r1_a(r1_a), .r1_b(r1_b), .r1_cmov(r1_cmov),
        .alu_is_cmov(alu_is_cmov), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
`ifdef ALU_ARB_GRANT_CNT_EN
        .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data)
    );

    function automatic logic [DW-1:0] alu_fn(input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cm);
        if (cm) return (a < b) ? a : b;
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            default: return b;
        endcase
    endfunction

    // Behavioural ALU plus CMOV front end driven by the arbiter.
    always_comb alu_result = alu_fn(alu_op, alu_a, alu_b, alu_is_cmov);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int id, input logic [OPW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic cm);
        f_op[id] = op;
        f_a[id]  = a;
        f_b[id]  = b;
        f_cm[id] = cm;
    endtask

    task automatic rand_fields(input int id);
        set_fields(id, OPW'($urandom_range(0, 5)), $urandom, $urandom, $urandom_range(0, 3) == 0);
    endtask

    task automatic do_reset();
        v[0] = 1'b0;
        v[1] = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        last_gnt = 1;
    endtask

    task automatic zero_check(input string tag);
        check({tag, "_rsp_valid"}, rsp_valid, 0);
        check({tag, "_rsp_id"}, rsp_id, 0);
        check({tag, "_rsp_data"}, rsp_data, 0);
        check({tag, "_readys"}, {r0_ready, r1_ready}, 0);
        check({tag, "_alu"}, {alu_is_cmov, alu_op, alu_a, alu_b}, 0);
    endtask

    // One op end to end: wait for the predicted grant, then check latency, data and hold behaviour.
    task automatic txn(input int hold, input bit keep, output int n);
        int who;
        int exp_who;
        logic [DW-1:0] exp_data;
        exp_who = (v[0] && v[1]) ? 1 - last_gnt : (v[1] ? 1 : 0);
        who = -1;
        n = 0;
        for (int i = 0; i < 20 && who < 0; i++) begin
            step();
            n++;
            if (r0_ready || r1_ready) who = r1_ready ? 1 : 0;
        end
        check("grant_seen", who >= 0, 1);
        if (who < 0) return;
        check("grant_id", who, exp_who);
        check("ready_exclusive", r0_ready & r1_ready, 0);
        check("alu_fields", {alu_is_cmov, alu_op, alu_a, alu_b}, {f_cm[who], f_op[who], f_a[who], f_b[who]});
        exp_data = alu_fn(f_op[who], f_a[who], f_b[who], f_cm[who]);
        last_gnt = who;
        if (keep) rand_fields(who);
        else v[who] = 1'b0;
        step();
        check("exec_no_rsp", {rsp_valid, r0_ready, r1_ready}, 0);
        step();
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, who);
        check("rsp_data", rsp_data, exp_data);
        for (int i = 0; i < hold; i++) begin
            step();
            check("hold_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, who[0], exp_data});
            check("hold_readys", {r0_ready, r1_ready}, 0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check("rsp_done", rsp_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_fields(0, '0, '0, '0, 1'b0);
        set_fields(1, '0, '0, '0, 1'b0);
        do_reset();
        zero_check("reset");

        set_fields(0, 4'd0, 32'h10, 32'h22, 1'b0);
        v[0] = 1'b1;
        rsp_ready = 1'b1;
        txn(0, 1'b0, lat);
        check("single_grant_lat", lat, 1);
        check("single_data", rsp_data, 32'h32);

        set_fields(1, 4'd2, 32'd7, 32'd3, 1'b1);
        v[1] = 1'b1;
        txn(0, 1'b0, lat);
        check("cmov_data", rsp_data, 32'd3);
        check("cmov_id", rsp_id, 1);

        do_reset();
        rand_fields(0);
        rand_fields(1);
        v[0] = 1'b1;
        v[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            txn(0, 1'b1, lat);
            check("fair_order", rsp_id, i % 2);
            check("fair_lat", lat, 1);
        end
        v[0] = 1'b0;
        v[1] = 1'b0;

        set_fields(0, 4'd1, 32'd100, 32'd42, 1'b0);
        v[0] = 1'b1;
        txn(5, 1'b1, lat);
        txn(0, 1'b0, lat);
        check("bp_regrant_lat", lat, 1);

        set_fields(0, 4'd0, 32'd5, 32'd9, 1'b0);
        v[0] = 1'b1;
        step();
        check("midop_ready", r0_ready, 1);
        v[0] = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_gnt = 1;
        zero_check("midop_reset");
        for (int i = 0; i < 4; i++) begin
            step();
            check("midop_no_rsp", rsp_valid, 0);
        end

        for (int r = 0; r < 40; r++) begin
            for (int id = 0; id < 2; id++)
                if (!v[id] && $urandom_range(0, 1) == 1) begin
                    rand_fields(id);
                    v[id] = 1'b1;
                end
            if (!v[0] && !v[1]) begin
                int k;
                k = $urandom_range(0, 1);
                rand_fields(k);
                v[k] = 1'b1;
            end
            txn($urandom_range(0, 3), $urandom_range(0, 1) == 1, lat);
        end
        v[0] = 1'b0;
        v[1] = 1'b0;

`ifdef ALU_ARB_GRANT_CNT_EN
        do_reset();
        check("cnt_reset", {gnt_cnt0, gnt_cnt1}, 0);
        for (int n = 1; n <= 5; n++) begin
            rand_fields(0);
            v[0] = 1'b1;
            txn(0, 1'b0, lat);
            check("gnt_cnt0", gnt_cnt0, (n < 3) ? n : 3);
            check("gnt_cnt1", gnt_cnt1, 0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
